// File: rtl/reg_list_sequencer.sv
// Gathers the values selected by a 17-bit source mask through an external 17:1 select and
// streams them out with valid/ready. Define REG_LIST_SEQ_REVERSE_EN for descending index order.
module reg_list_sequencer #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [16:0]      mask,
    output logic [4:0]       sel,
    input  logic [width-1:0] mux_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [4:0]       out_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [16:0]      r_mask;
    logic [16:0]      w_mask_nxt;
    logic [16:0]      w_mask_clr;
    logic [4:0]       w_pick;
    logic             w_slot;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [width-1:0] r_out_data;
    logic [width-1:0] w_out_data_nxt;
    logic [4:0]       r_out_idx;
    logic [4:0]       w_out_idx_nxt;

    // Priority pick over the pending mask; the last match in loop order wins.
    always_comb begin
        w_pick = 5'd0;
`ifdef REG_LIST_SEQ_REVERSE_EN
        for (int i = 0; i < 17; i++) begin
            if (r_mask[i]) begin
                w_pick = 5'(i);
            end
        end
`else
        for (int i = 16; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_pick = 5'(i);
            end
        end
`endif
    end

    assign w_mask_clr = r_mask & ~(17'd1 << w_pick);
    assign w_slot     = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_idx_nxt   = r_out_idx;
        sel             = 5'd0;
        busy            = (r_state != StIdle);
        done            = 1'b0;

        // An accepted value retires unless a new one is loaded below.
        if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_mask_nxt  = mask;
                    w_state_nxt = (mask == 17'd0) ? StFin : StRun;
                end
            end
            StRun: begin
                sel = w_pick;
                if (w_slot) begin
                    w_out_data_nxt  = mux_data;
                    w_out_idx_nxt   = w_pick;
                    w_out_valid_nxt = 1'b1;
                    w_mask_nxt      = w_mask_clr;
                    if (w_mask_clr == 17'd0) begin
                        w_state_nxt = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_slot) begin
                    w_state_nxt = StFin;
                end
            end
            StFin: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_mask      <= 17'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;

endmodule
